// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared operation codes and FSM state encodings for the multiply/divide unit.
//   Contents: MD_OP_WIDTH, md_op_e (MD_OP_NOP..MD_OP_MTLO), md_state_e (MD_ST_IDLE/CALC/FIX).
package muldiv_pkg;

    localparam int MD_OP_WIDTH = 3;

    // Code 7 is left unnamed and decodes as a no-op.
    typedef enum logic [MD_OP_WIDTH-1:0] {
        MD_OP_NOP   = 3'd0,
        MD_OP_MULT  = 3'd1,
        MD_OP_MULTU = 3'd2,
        MD_OP_DIV   = 3'd3,
        MD_OP_DIVU  = 3'd4,
        MD_OP_MTHI  = 3'd5,
        MD_OP_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_CALC = 2'd1,
        MD_ST_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or restoring divide.
//   is_div_i : 1 = divide step, 0 = multiply step
//   acc_i    : 2*WIDTH working register ({partial product, multiplier} or {remainder, quotient})
//   opd_i    : multiplicand or divisor magnitude
//   acc_o    : working register after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_s;
    logic [WIDTH:0] diff;

    // Multiply: add the multiplicand when the current multiplier LSB is set, then
    // shift the whole register right, keeping the carry as the new top bit.
    assign sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opd_i} : {(WIDTH+1){1'b0}});
    // Divide: shift the next dividend bit into the remainder and trial-subtract;
    // a clear borrow bit means the subtraction stands and the quotient bit is 1.
    assign rem_s = acc_i[2*WIDTH-1:WIDTH-1];
    assign diff  = rem_s - {1'b0, opd_i};

    assign acc_o = is_div_i
                 ? {(diff[WIDTH] ? rem_s[WIDTH-1:0] : diff[WIDTH-1:0]), acc_i[WIDTH-2:0], ~diff[WIDTH]}
                 : {sum, acc_i[WIDTH-1:1]};

endmodule

// File: rtl/muldiv.sv
// muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and direct MTHI/MTLO writes.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start, op  : request strobe and operation code (md_op_e; 7 = no-op)
//   a, b       : multiplicand/dividend (also MTHI/MTLO source), multiplier/divisor
//   busy       : iterative operation in progress (33 cycles)
//   done       : one-cycle pulse when an iterative result lands in HI/LO
//   hi, lo     : HI and LO registers
module muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [MD_OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       hi,
    output logic [WIDTH-1:0]       lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               done_q, done_d;

    logic               is_mul_op, is_div_op, is_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign is_mul_op = (op == MD_OP_MULT) || (op == MD_OP_MULTU);
    assign is_div_op = (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
    assign is_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);
    assign abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;

    // For multiply neg_lo_q carries the product sign (applied to all 2*WIDTH bits);
    // for divide it is the quotient sign and neg_hi_q the remainder sign.
    assign prod_fix = neg_lo_q ? -acc_q : acc_q;
    assign q_fix    = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign r_fix    = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opd_i    (opd_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        done_d   = 1'b0;
        case (state_q)
            MD_ST_IDLE: begin
                if (start && (is_mul_op || is_div_op)) begin
                    acc_d    = {{WIDTH{1'b0}}, (is_div_op ? abs_a : abs_b)};
                    opd_d    = is_div_op ? abs_b : abs_a;
                    is_div_d = is_div_op;
                    // Divide by zero leaves the raw all-ones quotient and a remainder of |a|;
                    // the remainder sign flip then restores a exactly, so only the
                    // quotient flip is suppressed.
                    neg_lo_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && !(is_div_op && b == '0);
                    neg_hi_d = is_signed && is_div_op && a[WIDTH-1];
                    cnt_d    = '0;
                    state_d  = MD_ST_CALC;
                end else if (start && op == MD_OP_MTHI) begin
                    hi_d = a;
                end else if (start && op == MD_OP_MTLO) begin
                    lo_d = a;
                end
            end
            MD_ST_CALC: begin
                acc_d   = acc_step;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH-1)) ? MD_ST_FIX : MD_ST_CALC;
            end
            MD_ST_FIX: begin
                hi_d    = is_div_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo_d    = is_div_q ? q_fix : prod_fix[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = MD_ST_IDLE;
            end
            default: state_d = MD_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != MD_ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: scoreboard bench for muldiv; a driver pushes expected HI/LO pairs from a
//   plain-arithmetic reference model, a monitor pops and compares on every done pulse.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] vis_hi = '0;
    logic [31:0] vis_lo = '0;

    muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference results straight from the arithmetic definition of each op.
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = {32'b0, x};
        longint unsigned uy = {32'b0, y};
        logic [31:0]     q, r;
        case (o)
            3'd1: return 64'(sx * sy);
            3'd2: return 64'(ux * uy);
            3'd3, 3'd4: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                q = (o == 3'd3) ? 32'(sx / sy) : 32'(ux / uy);
                r = (o == 3'd3) ? 32'(sx % sy) : 32'(ux % uy);
                return {r, q};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Monitor: busy-length, one-cycle done, hold-during-CALC and result checks.
    int   busy_cnt = 0;
    logic prev_done = 1'b0;
    always @(negedge clk or negedge rst_n) begin
        logic [63:0] e;
        if (!rst_n) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("done_width", {63'b0, done}, 64'd0);
            if (busy) begin
                busy_cnt++;
                check("hold_during_calc", {hi, lo}, {vis_hi, vis_lo});
            end
            if (done) begin
                check("busy_len", 64'(busy_cnt), 64'd33);
                check("busy_low_at_done", {63'b0, busy}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_hi_lo", {hi, lo}, e);
                    vis_hi = e[63:32];
                    vis_lo = e[31:0];
                end
                busy_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        wait_idle();
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        if (o >= 3'd1 && o <= 3'd4) begin
            exp_q.push_back(ref_md(o, x, y));
        end else begin
            if (o == 3'd5) vis_hi = x;
            if (o == 3'd6) vis_lo = x;
            check("no_busy_mt_nop", {63'b0, busy}, 64'd0);
            check("mt_nop_hi_lo", {hi, lo}, {vis_hi, vis_lo});
        end
    endtask

    // Request offered while busy: must not be accepted.
    task automatic poke_busy(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        check("ignored_while_busy", {hi, lo}, {vis_hi, vis_lo});
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    initial begin
        vec_t vecs[$];
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        vecs = '{
            '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF},
            '{3'd1, 32'hFFFFFFFE, 32'h00000003},
            '{3'd1, 32'h80000000, 32'h80000000},
            '{3'd3, 32'hFFFFFFF9, 32'h00000002},
            '{3'd4, 32'h00000007, 32'h00000002},
            '{3'd3, 32'h12345678, 32'h00000000},
            '{3'd3, 32'h80000000, 32'hFFFFFFFF},
            '{3'd3, 32'h80000001, 32'h00000000},
            '{3'd4, 32'hF0000000, 32'h00000000},
            '{3'd3, 32'h00000007, 32'hFFFFFFFE}
        };
        #12;
        check("reset_outputs", {62'b0, busy, done, 32'b0} | {32'b0, 32'b0}, 64'd0);
        check("reset_hi_lo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) issue(vecs[i].o, vecs[i].x, vecs[i].y);
        drain();
        check("multu_max", {hi, lo}, {vis_hi, vis_lo});

        issue(3'd5, 32'hCAFEBABE, 32'h0);
        check("mthi_value", {32'b0, hi}, {32'b0, 32'hCAFEBABE});

        issue(3'd4, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        poke_busy(3'd1, 32'h11111111, 32'h22222222);
        repeat (5) @(negedge clk);
        poke_busy(3'd6, 32'hDEADBEEF, 32'h0);
        drain();
        check("divu_after_ignored", {hi, lo}, {32'h00000002, 32'h0000000E});

        issue(3'd2, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        vis_hi = '0;
        vis_lo = '0;
        #1;
        check("async_reset_mid_calc", {30'b0, busy, done, hi}, 64'd0);
        check("async_reset_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd2, 32'd3, 32'd5);
        drain();
        check("multu_after_reset", {hi, lo}, {32'h0, 32'h0000000F});

        for (int k = 0; k < 30; k++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 7) == 0) ry = '0;
            if ($urandom_range(0, 15) == 0) begin
                rx = 32'h80000000;
                ry = 32'hFFFFFFFF;
            end
            if ($urandom_range(0, 3) == 0) ry = ry >> $urandom_range(1, 31);
            issue(ro, rx, ry);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
